hazard_unit_fwd: RTL
====================

// Module: hazard_unit_fwd
// PURPOSE
//  Next-gen pipeline hazard unit for the 5-stage RV32I core. Decodes D/E/M/W instructions, generates stage enables/flushes, forwarding selects
//  for the EX operands, load-use stalls and control-flow flushes. Adds a sequential memory-wait FSM with timeout and saturating perf counters.
//  Sits beside the pipeline registers; all pipeline regs and the PC consume its enable/flush outputs.
// PARAMETERS
//  FWD_EN       1    1: forward from M/W, stall only on load-use; 0: stall on any RAW against E/M/W
//  MEM_TIMEOUT  255  max consecutive MEM_WAIT cycles before ERR (>=1)
//  TO_W         8    width of wait counter, must hold MEM_TIMEOUT
//  CNT_W        32   width of perf counters (saturating)
// PORTS
//  clk           in   1      core clock
//  rst           in   1      synchronous reset, active-high
//  instr_D/E/M/W in   32     instruction held in each stage register
//  valid_D/E/M/W in   1      stage holds a real instruction (0 = bubble)
//  is_taken      in   1      EX resolved redirect (branch taken / jal / jalr)
//  mem_rsp_valid in   1      load data available this cycle for load in M
//  pc_enable     out  1      PC update enable
//  IF_ID_enable/IF_ID_flush, ID_EX_enable/ID_EX_flush, EX_ME_enable/EX_ME_flush, ME_WB_enable/ME_WB_flush  out 1 each
//  fwd_a_sel     out  2      EX rs1 source: 00 regfile, 01 M result, 10 W result
//  fwd_b_sel     out  2      EX rs2 source, same encoding
//  mem_timeout   out  1      sticky: memory wait exceeded MEM_TIMEOUT
//  stall_cnt     out  CNT_W  cycles with pc_enable=0 (excluding reset)
//  flush_cnt     out  CNT_W  redirect flush events
// BEHAVIOUR
//  Decode: writes_rd = valid & opcode in {LUI,AUIPC,JAL,JALR,LOAD,OP-IMM,OP} & rd!=0. uses_rs1 = opcode not in {LUI,AUIPC,JAL};
//   uses_rs2 = opcode in {BRANCH,STORE,OP}. Comparisons only count for used sources; x0 never matches.
//  Reset (rst=1): state IDLE, wait_cnt=0, mem_timeout=0, counters=0; outputs pc_enable=0, all *_enable=1, all *_flush=1, fwd_*_sel=00.
//  FSM IDLE/MEM_WAIT/ERR, registered on clk:
//   IDLE: valid load in M & !mem_rsp_valid -> MEM_WAIT, wait_cnt<=1. Else stay.
//   MEM_WAIT: mem_rsp_valid -> IDLE, wait_cnt<=0; else wait_cnt++; wait_cnt==MEM_TIMEOUT & !mem_rsp_valid -> ERR, mem_timeout<=1.
//   ERR: held until rst; mem_timeout stays 1.
//  mem_freeze = (load_M & !mem_rsp_valid) | state==ERR: combinational, effective in the same cycle the load arrives in M.
//  Output priority (highest first), defaults pc/all enables=1, all flushes=0:
//   1 mem_freeze: pc_enable, IF_ID/ID_EX/EX_ME_enable=0; ME_WB_flush=1 (bubble into W). Redirect in E is held, applied after.
//   2 redirect: is_taken & valid_E & E in {BRANCH,JAL,JALR}: IF_ID_flush=1, ID_EX_flush=1; pc_enable=1. Overrides D stall.
//   3 FWD_EN=1 load-use: load_E writes rd matching used rs of D -> pc_enable=0, IF_ID_enable=0, ID_EX_flush=1 (one bubble).
//     FWD_EN=0 RAW: any writer in E, M or W matching used rs of D -> same stall pattern, repeats until clear.
//  Forwarding (FWD_EN=1; else fwd_*_sel=00): per EX source, M writer match -> 01, else W writer match -> 10, else 00. M wins over W.
//   M result includes load data (M-stage mux), valid since freeze guarantees mem_rsp_valid before M advances.
//  Counters: stall_cnt += 1 each non-reset cycle with pc_enable=0; flush_cnt += 1 per redirect cycle; both saturate at all-ones.
//  Simultaneous: freeze + redirect -> freeze only, no flush count; load-use + redirect -> redirect only; rst mid-MEM_WAIT -> IDLE next cycle.
// TESTING
//  add x5 in M, sub x6,x5,x1 in E (FWD_EN=1) -> fwd_a_sel=01, no stall; with x5 only in W -> fwd_a_sel=10.
//  lw x5 in E, add x7,x5,x5 in D -> exactly 1 cycle pc_enable=0, ID_EX_flush=1; next cycle fwd_a_sel=fwd_b_sel=01.
//  lw in M, mem_rsp_valid low 3 cycles -> pc_enable=0 and ME_WB_flush=1 for 3 cycles, state MEM_WAIT, stall_cnt +3.
//  MEM_TIMEOUT=4, mem_rsp_valid never -> mem_timeout=1 at 5th wait cycle, pipeline frozen until rst; rst -> mem_timeout=0.
//  beq taken in E while D has load-use stall -> IF_ID_flush=ID_EX_flush=1, pc_enable=1, flush_cnt +1.
//  FWD_EN=0, add x5 in W, or x8,x5,x0 in D -> 1 stall cycle; x0 destinations (rd=0) never stall or forward.

Source files
------------

// File: rtl/hazard_unit_fwd_if.sv
// Pipeline-side bundle for the hazard unit: stage instructions in, stage controls, forwarding selects and perf state out.
interface hazard_unit_fwd_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      instr_D, instr_E, instr_M, instr_W;
  logic             valid_D, valid_E, valid_M, valid_W;
  logic             is_taken;
  logic             mem_rsp_valid;

  logic             pc_enable;
  logic             IF_ID_enable, IF_ID_flush;
  logic             ID_EX_enable, ID_EX_flush;
  logic             EX_ME_enable, EX_ME_flush;
  logic             ME_WB_enable, ME_WB_flush;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output instr_D, instr_E, instr_M, instr_W,
    output valid_D, valid_E, valid_M, valid_W,
    output is_taken, mem_rsp_valid,
    input  pc_enable, IF_ID_enable, IF_ID_flush, ID_EX_enable, ID_EX_flush,
    input  EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush,
    input  fwd_a_sel, fwd_b_sel, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_D, instr_E, instr_M, instr_W,
    input  valid_D, valid_E, valid_M, valid_W,
    input  is_taken, mem_rsp_valid,
    output pc_enable, IF_ID_enable, IF_ID_flush, ID_EX_enable, ID_EX_flush,
    output EX_ME_enable, EX_ME_flush, ME_WB_enable, ME_WB_flush,
    output fwd_a_sel, fwd_b_sel, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_fwd.sv
// RV32I 5-stage hazard unit: stage enables/flushes, EX operand forwarding, load-use/RAW stalls,
// redirect flushes, memory-wait FSM with timeout and saturating perf counters.
module hazard_unit_fwd #(
  parameter bit          FWD_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned CNT_W       = 32
) (
  input logic              clk,
  input logic              rst,
  hazard_unit_fwd_if.slave bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_ERR} state_t;

  function automatic logic writes_rd(input logic v, input logic [6:0] op, input logic [4:0] rd);
    return v && (rd != 5'd0) &&
           (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP});
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_BRANCH, OP_STORE, OP_OP};
  endfunction

  // Writer rd is already non-zero when wr is set, so x0 never matches.
  function automatic logic hit(input logic wr, input logic [4:0] rd, input logic use_rs, input logic [4:0] rs);
    return wr && use_rs && (rd == rs);
  endfunction

  logic [6:0] op_d, op_e, op_m, op_w;
  logic [4:0] rd_e, rd_m, rd_w;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e;
  logic       wr_e, wr_m, wr_w;
  logic       u1_d, u2_d, u1_e, u2_e;
  logic       dep_e, dep_m, dep_w;
  logic       load_m, load_use, d_stall, redirect, mem_freeze;
  logic       unused_instr_bits;

  assign op_d  = bus.instr_D[6:0];
  assign op_e  = bus.instr_E[6:0];
  assign op_m  = bus.instr_M[6:0];
  assign op_w  = bus.instr_W[6:0];
  assign rd_e  = bus.instr_E[11:7];
  assign rd_m  = bus.instr_M[11:7];
  assign rd_w  = bus.instr_W[11:7];
  assign rs1_d = bus.instr_D[19:15];
  assign rs2_d = bus.instr_D[24:20];
  assign rs1_e = bus.instr_E[19:15];
  assign rs2_e = bus.instr_E[24:20];

  assign unused_instr_bits = ^{bus.instr_D[31:25], bus.instr_D[14:7], bus.instr_E[31:25],
                               bus.instr_E[14:12], bus.instr_M[31:12], bus.instr_W[31:12]};

  assign wr_e = writes_rd(bus.valid_E, op_e, rd_e);
  assign wr_m = writes_rd(bus.valid_M, op_m, rd_m);
  assign wr_w = writes_rd(bus.valid_W, op_w, rd_w);
  assign u1_d = bus.valid_D && uses_rs1(op_d);
  assign u2_d = bus.valid_D && uses_rs2(op_d);
  assign u1_e = bus.valid_E && uses_rs1(op_e);
  assign u2_e = bus.valid_E && uses_rs2(op_e);

  // D-stage dependence on each downstream writer
  assign dep_e = hit(wr_e, rd_e, u1_d, rs1_d) || hit(wr_e, rd_e, u2_d, rs2_d);
  assign dep_m = hit(wr_m, rd_m, u1_d, rs1_d) || hit(wr_m, rd_m, u2_d, rs2_d);
  assign dep_w = hit(wr_w, rd_w, u1_d, rs1_d) || hit(wr_w, rd_w, u2_d, rs2_d);

  assign load_m   = bus.valid_M && (op_m == OP_LOAD);
  assign load_use = wr_e && (op_e == OP_LOAD) && dep_e;
  assign d_stall  = FWD_EN ? load_use : (dep_e || dep_m || dep_w);
  assign redirect = bus.is_taken && bus.valid_E && (op_e inside {OP_BRANCH, OP_JAL, OP_JALR});

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             timeout_q, timeout_d;

  assign mem_freeze = (load_m && !bus.mem_rsp_valid) || (state_q == S_ERR);

  // Memory-wait FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  // Memory-wait FSM next state
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_m && !bus.mem_rsp_valid) begin
          state_d = S_MEM_WAIT;
          wait_d  = TO_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d = S_IDLE;
          wait_d  = '0;
        end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_ERR: timeout_d = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  logic       pc_en_c, if_id_en_c, if_id_fl_c, id_ex_en_c, id_ex_fl_c;
  logic       ex_me_en_c, ex_me_fl_c, me_wb_en_c, me_wb_fl_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  // Stage controls: freeze > redirect > D-stage stall
  always_comb begin
    pc_en_c    = 1'b1;
    if_id_en_c = 1'b1;
    id_ex_en_c = 1'b1;
    ex_me_en_c = 1'b1;
    me_wb_en_c = 1'b1;
    if_id_fl_c = 1'b0;
    id_ex_fl_c = 1'b0;
    ex_me_fl_c = 1'b0;
    me_wb_fl_c = 1'b0;
    fwd_a_c    = 2'b00;
    fwd_b_c    = 2'b00;
    if (rst) begin
      pc_en_c    = 1'b0;
      if_id_fl_c = 1'b1;
      id_ex_fl_c = 1'b1;
      ex_me_fl_c = 1'b1;
      me_wb_fl_c = 1'b1;
    end else begin
      if (mem_freeze) begin
        pc_en_c    = 1'b0;
        if_id_en_c = 1'b0;
        id_ex_en_c = 1'b0;
        ex_me_en_c = 1'b0;
        me_wb_fl_c = 1'b1;
      end else if (redirect) begin
        if_id_fl_c = 1'b1;
        id_ex_fl_c = 1'b1;
      end else if (d_stall) begin
        pc_en_c    = 1'b0;
        if_id_en_c = 1'b0;
        id_ex_fl_c = 1'b1;
      end
      if (FWD_EN) begin
        if (hit(wr_m, rd_m, u1_e, rs1_e))      fwd_a_c = 2'b01;
        else if (hit(wr_w, rd_w, u1_e, rs1_e)) fwd_a_c = 2'b10;
        if (hit(wr_m, rd_m, u2_e, rs2_e))      fwd_b_c = 2'b01;
        else if (hit(wr_w, rd_w, u2_e, rs2_e)) fwd_b_c = 2'b10;
      end
    end
  end

  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_c && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (redirect && !mem_freeze && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.pc_enable    = pc_en_c;
  assign bus.IF_ID_enable = if_id_en_c;
  assign bus.IF_ID_flush  = if_id_fl_c;
  assign bus.ID_EX_enable = id_ex_en_c;
  assign bus.ID_EX_flush  = id_ex_fl_c;
  assign bus.EX_ME_enable = ex_me_en_c;
  assign bus.EX_ME_flush  = ex_me_fl_c;
  assign bus.ME_WB_enable = me_wb_en_c;
  assign bus.ME_WB_flush  = me_wb_fl_c;
  assign bus.fwd_a_sel    = fwd_a_c;
  assign bus.fwd_b_sel    = fwd_b_c;
  assign bus.mem_timeout  = timeout_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule
